// File: rtl/contador_mod_n_if.sv
// Bus bundle for contador_mod_n.
//   master: drives enable/load/up_down/entrada/compare, observes the count side
//   slave : the counter itself
//   enable   count enable           load    synchronous parallel load
//   up_down  1 = up, 0 = down       entrada load value
//   compare  match reference        contador current count
//   tc       terminal count (comb)  wrap    one-cycle boundary wrap pulse
//   sat      blocked-at-boundary    match   contador == compare (registered)
interface contador_mod_n_if #(
  parameter int WIDTH = 8
) ();
  logic             enable;
  logic             load;
  logic             up_down;
  logic [WIDTH-1:0] entrada;
  logic [WIDTH-1:0] compare;
  logic [WIDTH-1:0] contador;
  logic             tc;
  logic             wrap;
  logic             sat;
  logic             match;

  modport master (
    output enable, load, up_down, entrada, compare,
    input  contador, tc, wrap, sat, match
  );

  modport slave (
    input  enable, load, up_down, entrada, compare,
    output contador, tc, wrap, sat, match
  );
endinterface

// File: rtl/contador_mod_n.sv
// contador_mod_n: modulo-(MAX+1) up/down counter with wrap or saturate mode.
//   clock  rising-edge clock
//   reset  synchronous, active-high
//   bus    contador_mod_n_if.slave (enable, load, up_down, entrada, compare
//          in; contador, tc, wrap, sat, match out)
// Priority per edge: reset > load > enable count > hold.
// tc is combinational so a following stage can use it as its enable in the
// same cycle (two WIDTH=4/MAX=9 stages give a 2-digit BCD counter).
module contador_mod_n #(
  parameter int          WIDTH    = 8,
  parameter int unsigned MAX      = 2**WIDTH - 1,
  parameter bit          SATURATE = 1'b0
) (
  input logic             clock,
  input logic             reset,
  contador_mod_n_if.slave bus
);

  if (WIDTH < 2 || MAX < 1 || MAX > 2**WIDTH - 1) begin : g_bad_param
    $error("contador_mod_n: illegal WIDTH/MAX combination");
  end

  localparam logic [WIDTH-1:0] MAXV = MAX[WIDTH-1:0];
  localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] cnt_q, cnt_nxt;
  logic             wrap_q, wrap_nxt;
  logic             sat_q, sat_nxt;
  logic             match_q;
  logic             at_max, at_zero;

  assign at_max  = (cnt_q == MAXV);
  assign at_zero = (cnt_q == '0);

  // Next state for the non-reset case; reset is applied in the register.
  always_comb begin
    cnt_nxt  = cnt_q;
    wrap_nxt = 1'b0;
    sat_nxt  = sat_q;     // sat holds while idle
    if (bus.load) begin
      cnt_nxt = (bus.entrada > MAXV) ? MAXV : bus.entrada;
      sat_nxt = 1'b0;
    end else if (bus.enable) begin
      if (bus.up_down) begin
        if (!at_max) begin
          cnt_nxt = cnt_q + ONE;
          sat_nxt = 1'b0;
        end else if (!SATURATE) begin
          cnt_nxt  = '0;
          wrap_nxt = 1'b1;
          sat_nxt  = 1'b0;
        end else begin
          sat_nxt = 1'b1;   // blocked at the top
        end
      end else begin
        if (!at_zero) begin
          cnt_nxt = cnt_q - ONE;
          sat_nxt = 1'b0;
        end else if (!SATURATE) begin
          cnt_nxt  = MAXV;
          wrap_nxt = 1'b1;
          sat_nxt  = 1'b0;
        end else begin
          sat_nxt = 1'b1;   // blocked at the bottom
        end
      end
    end
  end

  // match is taken from the next-state count so it lines up with contador.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q   <= '0;
      wrap_q  <= 1'b0;
      sat_q   <= 1'b0;
      match_q <= (bus.compare == '0);
    end else begin
      cnt_q   <= cnt_nxt;
      wrap_q  <= wrap_nxt;
      sat_q   <= sat_nxt;
      match_q <= (cnt_nxt == bus.compare);
    end
  end

  assign bus.contador = cnt_q;
  assign bus.wrap     = wrap_q;
  assign bus.sat      = sat_q;
  assign bus.match    = match_q;
  assign bus.tc       = bus.enable & ~bus.load & ~reset &
                        ((bus.up_down & at_max) | (~bus.up_down & at_zero));

endmodule

// File: tb/tb_contador_mod_n.sv
module tb_contador_mod_n;

  logic clk;
  logic rst_a, rst_b, rst_c;
  int   total = 0;
  int   bad   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  contador_mod_n_if #(.WIDTH(4)) ia  ();
  contador_mod_n_if #(.WIDTH(8)) ib  ();
  contador_mod_n_if #(.WIDTH(4)) ic1 ();
  contador_mod_n_if #(.WIDTH(4)) ic2 ();

  contador_mod_n #(.WIDTH(4), .MAX(9),   .SATURATE(1'b0)) u_a  (.clock(clk), .reset(rst_a), .bus(ia));
  contador_mod_n #(.WIDTH(8), .MAX(200), .SATURATE(1'b1)) u_b  (.clock(clk), .reset(rst_b), .bus(ib));
  contador_mod_n #(.WIDTH(4), .MAX(9),   .SATURATE(1'b0)) u_c1 (.clock(clk), .reset(rst_c), .bus(ic1));
  contador_mod_n #(.WIDTH(4), .MAX(9),   .SATURATE(1'b0)) u_c2 (.clock(clk), .reset(rst_c), .bus(ic2));

  // Cascade: tens digit counts when the units digit is about to wrap.
  assign ic2.enable = ic1.tc;

  typedef struct {
    string tag;
    int    cnt;
    int    wrap;
    int    sat;
    int    match;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  int   q_c[$];

  task automatic cmp(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic pop_check(input bit is_b);
    exp_t e;
    if ((is_b ? q_b.size() : q_a.size()) == 0) begin
      cmp("scoreboard_empty", 0, 1);
      return;
    end
    e = is_b ? q_b.pop_front() : q_a.pop_front();
    if (is_b) begin
      cmp({e.tag, ".cnt"},   int'(ib.contador), e.cnt);
      cmp({e.tag, ".wrap"},  int'(ib.wrap),     e.wrap);
      cmp({e.tag, ".sat"},   int'(ib.sat),      e.sat);
      cmp({e.tag, ".match"}, int'(ib.match),    e.match);
    end else begin
      cmp({e.tag, ".cnt"},   int'(ia.contador), e.cnt);
      cmp({e.tag, ".wrap"},  int'(ia.wrap),     e.wrap);
      cmp({e.tag, ".sat"},   int'(ia.sat),      e.sat);
      cmp({e.tag, ".match"}, int'(ia.match),    e.match);
    end
  endtask

  // One clock of DUT A. exp_tc < 0 skips the tc check.
  task automatic a_step(input string tag, input bit rst, input bit en, input bit ld,
                        input bit ud, input int ent, input int cmpv, input int exp_tc,
                        input int exp_cnt, input int exp_wrap, input int exp_match);
    logic [31:0] v;
    rst_a = rst; ia.enable = en; ia.load = ld; ia.up_down = ud;
    v = ent;  ia.entrada = v[3:0];
    v = cmpv; ia.compare = v[3:0];
    q_a.push_back('{tag, exp_cnt, exp_wrap, 0, exp_match});
    #1;
    if (exp_tc >= 0) cmp({tag, ".tc"}, int'(ia.tc), exp_tc);
    @(posedge clk); #1;
    pop_check(1'b0);
  endtask

  task automatic b_step(input string tag, input bit rst, input bit en, input bit ld,
                        input bit ud, input int ent, input int exp_tc,
                        input int exp_cnt, input int exp_sat, input int exp_match);
    logic [31:0] v;
    rst_b = rst; ib.enable = en; ib.load = ld; ib.up_down = ud;
    v = ent; ib.entrada = v[7:0];
    ib.compare = 8'd200;
    q_b.push_back('{tag, exp_cnt, 0, exp_sat, exp_match});
    #1;
    if (exp_tc >= 0) cmp({tag, ".tc"}, int'(ib.tc), exp_tc);
    @(posedge clk); #1;
    pop_check(1'b1);
  endtask

  int up_seq[12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};

  initial begin
    int wraps2;
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    ia.enable = 0; ia.load = 0; ia.up_down = 1; ia.entrada = '0; ia.compare = 4'd3;
    ib.enable = 0; ib.load = 0; ib.up_down = 1; ib.entrada = '0; ib.compare = 8'd200;
    ic1.enable = 0; ic1.load = 0; ic1.up_down = 1; ic1.entrada = '0; ic1.compare = '0;
    ic2.load = 0; ic2.up_down = 1; ic2.entrada = '0; ic2.compare = '0;

    // ---- DUT A: WIDTH=4, MAX=9, wrap mode, compare=3 ----
    a_step("a_reset", 1, 0, 0, 1, 0, 3, 0, 0, 0, 0);
    for (int i = 0; i < 12; i++)
      a_step($sformatf("a_up%0d", i), 0, 1, 0, 1, 0, 3, (i == 9) ? 1 : 0,
             up_seq[i], (up_seq[i] == 0) ? 1 : 0, (up_seq[i] == 3) ? 1 : 0);
    a_step("a_up_to3",  0, 1, 0, 1, 0, 3, 0, 3, 0, 1);
    a_step("a_hold3_0", 0, 0, 0, 1, 0, 3, 0, 3, 0, 1);
    a_step("a_hold3_1", 0, 0, 0, 0, 0, 3, 0, 3, 0, 1);
    // down count from a load of 1
    a_step("a_load1",   0, 1, 1, 0, 1, 3, 0, 1, 0, 0);
    a_step("a_dn0",     0, 1, 0, 0, 0, 3, 0, 0, 0, 0);
    a_step("a_dn_wrap", 0, 1, 0, 0, 0, 3, 1, 9, 1, 0);
    a_step("a_dn8",     0, 1, 0, 0, 0, 3, 0, 8, 0, 0);
    // clamp of an out-of-range load; load masks tc at the top
    a_step("a_load15",  0, 1, 1, 1, 15, 3, 0, 9, 0, 0);
    a_step("a_load_tc", 0, 1, 1, 1, 15, 3, 0, 9, 0, 0);
    // reset beats load and enable; tc masked by reset at the top
    a_step("a_rst_all", 1, 1, 1, 1, 5, 3, 0, 0, 0, 0);
    a_step("a_load5",   0, 1, 1, 1, 5, 3, 0, 5, 0, 0);
    // match on reset reflects compare==0
    a_step("a_rst_cmp0", 1, 0, 0, 1, 0, 0, 0, 0, 0, 1);

    // ---- DUT B: WIDTH=8, MAX=200, saturate mode, compare=200 ----
    b_step("b_reset",    1, 0, 0, 1, 0,   0, 0,   0, 0);
    b_step("b_dn_block", 0, 1, 0, 0, 0,   1, 0,   1, 0);
    b_step("b_idle",     0, 0, 0, 0, 0,   0, 0,   1, 0);
    b_step("b_load199",  0, 0, 1, 1, 199, 0, 199, 0, 0);
    b_step("b_up1",      0, 1, 0, 1, 0,   0, 200, 0, 1);
    b_step("b_up2",      0, 1, 0, 1, 0,   1, 200, 1, 1);
    b_step("b_up3",      0, 1, 0, 1, 0,   1, 200, 1, 1);
    b_step("b_dn",       0, 1, 0, 0, 0,   0, 199, 0, 0);
    b_step("b_load255",  0, 0, 1, 1, 255, 0, 200, 0, 1);

    // ---- Cascade: two BCD digits, 100 counts ----
    @(negedge clk);
    rst_c = 1'b1; ic1.enable = 1'b1;
    @(posedge clk); #1;
    cmp("c_reset", 10 * int'(ic2.contador) + int'(ic1.contador), 0);
    rst_c = 1'b0;
    wraps2 = 0;
    for (int i = 1; i <= 100; i++) begin
      q_c.push_back(i % 100);
      @(posedge clk); #1;
      if (ic2.wrap) wraps2++;
      cmp($sformatf("c_val%0d", i), 10 * int'(ic2.contador) + int'(ic1.contador),
          q_c.pop_front());
    end
    cmp("c_wrap2_count", wraps2, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/contador_mod_n.md
# contador_mod_n

Parametrised synchronous up/down counter with a configurable width and terminal value, and a selectable wrap or saturate mode. It adds count-enable, a terminal-count output for cascading, registered wrap/saturation event pulses and a compare-match output. It replaces the fixed 4-bit up/down counter in timer, prescaler and sequencing datapaths.

## Interface
- WIDTH, 8, counter width in bits (≥2)
- MAX, 2**WIDTH-1, terminal (highest) count value, 1 ≤ MAX ≤ 2**WIDTH-1
- SATURATE, 0, 0 = wrap at the boundaries; 1 = hold at the boundaries

- clock  in  1  rising-edge clock; the only clock
- reset  in  1  synchronous reset, active-high
- enable  in  1  count enable; no count when low
- load  in  1  synchronous parallel load; takes priority over counting
- up_down  in  1  1 = count up, 0 = count down
- entrada  in  WIDTH  load value
- compare  in  WIDTH  match reference
- contador  out  WIDTH  current count (registered)
- tc  out  1  terminal count (combinational), for cascading the next stage's enable
- wrap  out  1  one-cycle registered pulse marking a boundary wrap
- sat  out  1  registered level marking a blocked count at a boundary (SATURATE=1 only)
- match  out  1  registered flag: contador == compare

## Operation
- Priority per rising clock edge: reset > load > (enable count) > hold.
- reset=1: contador←0, wrap←0, sat←0, match←(compare==0) evaluated on the next edge. All outputs are 0 in the cycle after reset, except match.
- load=1: contador←min(entrada, MAX); wrap←0; sat←0. Loads ignore enable and up_down.
- enable=1, load=0, up_down=1:
  - contador<MAX: contador+1.
  - contador==MAX with SATURATE=0: contador←0 and wrap←1.
  - contador==MAX with SATURATE=1: contador holds and sat←1.
- enable=1, load=0, up_down=0:
  - contador>0: contador-1.
  - contador==0 with SATURATE=0: contador←MAX and wrap←1.
  - contador==0 with SATURATE=1: contador holds and sat←1.
- Clearing the flags:
  - wrap is 1 only for the cycle following the wrapping edge. It is cleared on any edge without a wrap.
  - sat clears on any edge where the counter moves, loads or resets. It holds while enable=0.
- tc = enable & ((up_down & contador==MAX) | (~up_down & contador==0)). tc is independent of SATURATE and is forced to 0 while load=1 or reset=1.
- match is registered from the next-state value of contador. It is therefore valid in the same cycle that contador shows the value.
- Arithmetic: modulo MAX+1, computed in WIDTH bits. The next-state logic never produces a value above MAX.
- Changing up_down at a boundary is legal. Direction is evaluated on every edge; there is no direction memory.

## Timing
- Single clock domain. All state updates on rising clock edges.
- Count latency: contador updates 1 cycle after the edge where enable is sampled high.
- Load latency: 1 cycle.
- Reset mid-count: takes effect on the next edge regardless of load/enable. No partial state survives.
- tc is combinational from contador, enable, up_down, load and reset. It is used to feed the next stage's enable in the same cycle. The cascade of two WIDTH=4, MAX=9 instances forms a 2-digit BCD counter.
- wrap and sat change on the same edge as the corresponding contador update. match changes on the same edge as contador.

## Test plan
- WIDTH=4, MAX=9, SATURATE=0. Reset, then enable=1, up_down=1 for 12 cycles → contador 1…9, 0, 1, 2. wrap=1 only in the cycle contador=0. tc=1 only while contador=9.
- Same configuration, counting down from a load of entrada=1 → 0, 9, 8. wrap pulses once at 9. Load entrada=15 → contador=9 (clamped).
- SATURATE=1, WIDTH=8, MAX=200. Load 199, count up 3 cycles → 200, 200, 200. sat=1 from the second count on. Switch to up_down=0 → 199 and sat=0.
- Simultaneous reset=1, load=1, enable=1 → contador=0 and wrap=0. Simultaneous load=1 and enable=1 with entrada=5 → contador=5 with no count applied.
- compare=3, count up from 0 → match=1 exactly in the cycle contador=3. Hold enable=0 at 3 → match stays 1.
- Two instances with WIDTH=4, MAX=9; stage 2 enable = stage 1 tc. Count 100 cycles from reset → {stage 2, stage 1} steps 00…99 then back to 00, with exactly one stage-2 wrap pulse.
